pipe_scoreboard: RTL

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

---
 rtl/pipe_scoreboard.sv | 94 +++++++++
 1 files changed

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: decode-stage hazard scoreboard with stall/flush control and forwarding select.
// Optional PIPE_SCOREBOARD_PERF_EN adds a saturating stall_cycles counter output.
module pipe_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_w,
  input  logic                  id_is_load,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic                  issue,
`ifdef PIPE_SCOREBOARD_PERF_EN
  output logic [31:0]           stall_cycles,
`endif
  output logic [1:0]            fwd_rs1,
  output logic [1:0]            fwd_rs2
);
  logic [1:0] cnt_q [NUM_REGS];
  logic [1:0] cnt_d [NUM_REGS];
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic ex_w_q, ex_w_d, mem_w_q, mem_w_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic [1:0] fwd_rs1_q, fwd_rs1_d, fwd_rs2_q, fwd_rs2_d;
  logic [2**REG_ADDR_W-1:0] busy;
  logic hazard, ex_live, mem_live, wr_cnt;
  // Indices at or beyond NUM_REGS, and x0, always read as ready.
  always_comb begin
    busy = '0;
    for (int i = 1; i < NUM_REGS; i++) busy[i] = cnt_q[i] != 2'd0;
  end
  always_comb begin
    hazard = id_valid & ((id_use_rs1 & busy[id_rs1]) | (id_use_rs2 & busy[id_rs2]) | (id_reg_w & busy[id_rd]));
    flush = ex_branch_taken | (flush_cnt_q != 2'd0);
    stall = hazard & ~flush;
    issue = id_valid & ~stall & ~flush;
    wr_cnt = issue & id_reg_w & (id_rd != '0);
    flush_cnt_d = ex_branch_taken ? 2'(FLUSH_CYCLES - 1) : (flush_cnt_q != 2'd0 ? flush_cnt_q - 2'd1 : 2'd0);
    cnt_d[0] = 2'd0;
    for (int i = 1; i < NUM_REGS; i++)
      cnt_d[i] = (wr_cnt && id_rd == REG_ADDR_W'(i)) ? (id_is_load ? 2'(LOAD_LATENCY) : 2'd0)
               : (cnt_q[i] != 2'd0 ? cnt_q[i] - 2'd1 : 2'd0);
    mem_w_d = ex_w_q;
    mem_rd_d = ex_rd_q;
    ex_w_d = issue & id_reg_w;
    ex_rd_d = issue ? id_rd : ex_rd_q;
    ex_live = ex_w_q & (ex_rd_q != '0);
    mem_live = mem_w_q & (mem_rd_q != '0);
    fwd_rs1_d = !issue ? 2'b00 : (ex_live && ex_rd_q == id_rs1) ? 2'b01 : (mem_live && mem_rd_q == id_rs1) ? 2'b10 : 2'b00;
    fwd_rs2_d = !issue ? 2'b00 : (ex_live && ex_rd_q == id_rs2) ? 2'b01 : (mem_live && mem_rd_q == id_rs2) ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= 2'd0;
      flush_cnt_q <= 2'd0;
      ex_w_q <= 1'b0;
      mem_w_q <= 1'b0;
      ex_rd_q <= '0;
      mem_rd_q <= '0;
      fwd_rs1_q <= 2'b00;
      fwd_rs2_q <= 2'b00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
      flush_cnt_q <= flush_cnt_d;
      ex_w_q <= ex_w_d;
      mem_w_q <= mem_w_d;
      ex_rd_q <= ex_rd_d;
      mem_rd_q <= mem_rd_d;
      fwd_rs1_q <= fwd_rs1_d;
      fwd_rs2_q <= fwd_rs2_d;
    end
  end
  assign fwd_rs1 = fwd_rs1_q;
  assign fwd_rs2 = fwd_rs2_q;
`ifdef PIPE_SCOREBOARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  always_comb stall_cycles_d = (stall && !(&stall_cycles_q)) ? stall_cycles_q + 32'd1 : stall_cycles_q;
  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else stall_cycles_q <= stall_cycles_d;
  end
  assign stall_cycles = stall_cycles_q;
`endif
endmodule
